// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared types for the RV32I multi-cycle sequencer.
//   state_e    - sequencer FSM states
//   op_class_e - instruction class decoded from opcode[6:0]
//   wb_sel_e   - register-file writeback source
//   op_*       - RV32I major opcodes
//   writes_rd / wb_source - per-class writeback properties
package core_seq_pkg;

   localparam logic [6:0] op_lui    = 7'b0110111;
   localparam logic [6:0] op_auipc  = 7'b0010111;
   localparam logic [6:0] op_jal    = 7'b1101111;
   localparam logic [6:0] op_jalr   = 7'b1100111;
   localparam logic [6:0] op_branch = 7'b1100011;
   localparam logic [6:0] op_load   = 7'b0000011;
   localparam logic [6:0] op_store  = 7'b0100011;
   localparam logic [6:0] op_imm    = 7'b0010011;
   localparam logic [6:0] op_reg    = 7'b0110011;
   localparam logic [6:0] op_fence  = 7'b0001111;

   typedef enum logic [2:0] {
      s_fetch,
      s_decode,
      s_execute,
      s_memory,
      s_writeback,
      s_halt
   } state_e;

   typedef enum logic [3:0] {
      cls_alu,
      cls_lui,
      cls_auipc,
      cls_jal,
      cls_jalr,
      cls_branch,
      cls_load,
      cls_store,
      cls_fence,
      cls_illegal
   } op_class_e;

   typedef enum logic [1:0] {
      wb_alu  = 2'd0,
      wb_mem  = 2'd1,
      wb_link = 2'd2
   } wb_sel_e;

   // Classes that produce a value for rd.
   function automatic logic writes_rd(input op_class_e c);
      case (c)
         cls_alu, cls_lui, cls_auipc, cls_jal, cls_jalr, cls_load: return 1'b1;
         default:                                                return 1'b0;
      endcase
   endfunction

   function automatic wb_sel_e wb_source(input op_class_e c);
      case (c)
         cls_load:         return wb_mem;
         cls_jal, cls_jalr: return wb_link;
         default:          return wb_alu;
      endcase
   endfunction

endpackage

// File: rtl/core_sequencer_op_classifier.sv
// op_classifier: combinational opcode decoder.
//   opcode   in  7   instruction bits [6:0]
//   op_class out     instruction class; anything unrecognised (incl. SYSTEM) is cls_illegal
module op_classifier
   import core_seq_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_e  op_class
);

   // NOTE: every variable written here gets a default first, so no input value leaves it unassigned and infers a latch.
   always_comb begin
      op_class = cls_illegal;
      case (opcode)
         op_lui:         op_class = cls_lui;
         op_auipc:       op_class = cls_auipc;
         op_jal:         op_class = cls_jal;
         op_jalr:        op_class = cls_jalr;
         op_branch:      op_class = cls_branch;
         op_load:        op_class = cls_load;
         op_store:       op_class = cls_store;
         op_imm, op_reg: op_class = cls_alu;
         op_fence:       op_class = cls_fence;
         default:        op_class = cls_illegal;
      endcase
   end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core; one instruction in flight.
//   clk, rst (sync, active-high)
//   instr_req/instr_valid/instr      instruction fetch handshake; instr_q is the latched word
//   pc_address                       current PC, held from DECODE through commit
//   alu_out/next_sel_address/branch_taken  execute-stage results, captured in EXECUTE
//   alu_q                            registered ALU result (data-memory address)
//   dmem_req/dmem_we/dmem_ready      data-memory handshake
//   rf_we/wb_sel                     register-file write strobe and source
//   retire                           one-cycle commit pulse
//   halted                           sticky; illegal opcode or misaligned target
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int                   DataWidth = 32,
   parameter logic [DataWidth-1:0] ResetAddr = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 instr_req,
   input  logic                 instr_valid,
   input  logic [DataWidth-1:0] instr,
   output logic [DataWidth-1:0] instr_q,
   output logic [DataWidth-1:0] pc_address,
   input  logic [DataWidth-1:0] alu_out,
   input  logic [DataWidth-1:0] next_sel_address,
   input  logic                 branch_taken,
   output logic [DataWidth-1:0] alu_q,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ready,
   output logic                 rf_we,
   output logic [1:0]           wb_sel,
   output logic                 retire,
   output logic                 halted
);

   state_e               state_q, state_d;
   op_class_e            op_class;
   logic [DataWidth-1:0] link_q;
   logic                 taken_q;
   logic [DataWidth-1:0] commit_pc;
   logic                 commit_now;
   logic                 misaligned;

   op_classifier u_op_classifier (
      .opcode   (instr_q[6:0]),
      .op_class (op_class)
   );

   // Next-PC selection; only meaningful in the commit cycle.
   always_comb begin
      commit_pc = link_q;
      case (op_class)
         cls_jal:    commit_pc = alu_q;
         cls_jalr:   commit_pc = {alu_q[DataWidth-1:1], 1'b0};
         cls_branch: commit_pc = taken_q ? alu_q : link_q;
         default:    commit_pc = link_q;
      endcase
   end

   // A store commits straight out of MEMORY; everything else commits in WRITEBACK.
   assign commit_now = (state_q == s_writeback) ||
                       ((state_q == s_memory) && dmem_ready && (op_class == cls_store));
   assign misaligned = commit_pc[1];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= s_fetch;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_address <= ResetAddr;
         instr_q    <= '0;
         alu_q      <= '0;
         link_q     <= '0;
         taken_q    <= 1'b0;
      end else begin
         if ((state_q == s_fetch) && instr_valid) instr_q <= instr;
         if (state_q == s_execute) begin
            alu_q   <= alu_out;
            link_q  <= next_sel_address;
            taken_q <= branch_taken;
         end
         if (commit_now && !misaligned) pc_address <= commit_pc;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         s_fetch:     if (instr_valid) state_d = s_decode;
         s_decode:    state_d = (op_class == cls_illegal) ? s_halt : s_execute;
         s_execute:   state_d = ((op_class == cls_load) || (op_class == cls_store)) ? s_memory
                                                                                    : s_writeback;
         s_memory: begin
            if (dmem_ready) begin
               if (op_class == cls_load) state_d = s_writeback;
               else                      state_d = misaligned ? s_halt : s_fetch;
            end
         end
         s_writeback: state_d = misaligned ? s_halt : s_fetch;
         s_halt:      state_d = s_halt;
         default:     state_d = s_fetch;
      endcase
   end

   always_comb begin
      // The reset cycle itself must not request a fetch.
      instr_req = (state_q == s_fetch) && !rst;
      dmem_req  = (state_q == s_memory);
      dmem_we   = (state_q == s_memory) && (op_class == cls_store);
      retire    = commit_now && !misaligned;
      rf_we     = (state_q == s_writeback) && !misaligned && writes_rd(op_class) &&
                  (instr_q[11:7] != 5'd0);
      wb_sel    = (state_q == s_writeback) ? wb_source(op_class) : wb_alu;
      halted    = (state_q == s_halt);
   end

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

   localparam logic [31:0] i_addi  = 32'h0050_0093;  // addi x1, x0, 5
   localparam logic [31:0] i_fence = 32'h0000_000F;
   localparam logic [31:0] i_lw    = 32'h0000_A103;  // lw x2, 0(x1)
   localparam logic [31:0] i_sw    = 32'h0011_2023;  // sw x1, 0(x2)
   localparam logic [31:0] i_beq   = 32'h0000_0063;  // beq x0, x0
   localparam logic [31:0] i_jal0  = 32'h0000_006F;  // jal x0
   localparam logic [31:0] i_jalr  = 32'h0001_00E7;  // jalr x1, 0(x2)
   localparam logic [31:0] i_sys   = 32'h0000_0073;  // ecall

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req, instr_valid;
   logic [31:0] instr, instr_q, pc_address, alu_out, next_sel_address, alu_q;
   logic        branch_taken, dmem_req, dmem_we, dmem_ready, rf_we, retire, halted;
   logic [1:0]  wb_sel;

   always #5 clk = ~clk;

   core_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .instr_req        (instr_req),
      .instr_valid      (instr_valid),
      .instr            (instr),
      .instr_q          (instr_q),
      .pc_address       (pc_address),
      .alu_out          (alu_out),
      .next_sel_address (next_sel_address),
      .branch_taken     (branch_taken),
      .alu_q            (alu_q),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_ready       (dmem_ready),
      .rf_we            (rf_we),
      .wb_sel           (wb_sel),
      .retire           (retire),
      .halted           (halted)
   );

   typedef struct {
      logic [31:0] cur;
      logic [31:0] nxt;
      logic        rf;
      logic [1:0]  wb;
   } sb_t;

   sb_t         sb[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [31:0] exp_pc;
   logic        pend = 1'b0;
   logic [31:0] pend_pc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   // Scoreboard: each retire pops the expectation pushed when the instruction was issued.
   always @(negedge clk) begin
      sb_t e;
      if (pend) begin
         check("commit_pc", pc_address, pend_pc);
         pend <= 1'b0;
      end
      if (rf_we) check("rf_we_without_retire", retire, 1'b1);
      if (retire) begin
         check("sb_one_in_flight", 32'(sb.size()), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("retire_pc", pc_address, e.cur);
            check("retire_rf_we", rf_we, e.rf);
            check("retire_wb_sel", wb_sel, e.wb);
            pend    <= 1'b1;
            pend_pc <= e.nxt;
         end
      end
   end

   // Issues one instruction from FETCH (called at posedge+1) and waits for its retire.
   task automatic run_simple(input string tag, input logic [31:0] word, input logic [31:0] alu,
                             input logic [31:0] link, input logic taken, input logic [31:0] nxt,
                             input logic rf, input logic [1:0] wb);
      int n;
      sb.push_back('{exp_pc, nxt, rf, wb});
      exp_pc           = nxt;
      instr            = word;
      instr_valid      = 1'b1;
      alu_out          = alu;
      next_sel_address = link;
      branch_taken     = taken;
      #1;
      check({tag, "_instr_req"}, instr_req, 1'b1);
      for (n = 1; n <= 8; n++) begin
         cyc();
         instr_valid = 1'b0;
         look();
         if (retire) break;
      end
      check({tag, "_latency"}, 32'(n), 32'd3);
      cyc();
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = '0; alu_out = '0; next_sel_address = '0;
      branch_taken = 1'b0; dmem_ready = 1'b0; exp_pc = 32'h0;

      cyc(); cyc(); look();
      check("rst_pc", pc_address, 32'h0);
      check("rst_instr_req", instr_req, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_retire", retire, 1'b0);
      check("rst_dmem_req", dmem_req, 1'b0);
      check("rst_rf_we", rf_we, 1'b0);
      check("rst_instr_q", instr_q, 32'h0);
      check("rst_alu_q", alu_q, 32'h0);
      cyc();
      rst = 1'b0;

      // ADDI with instr_valid in the very first FETCH cycle.
      run_simple("addi", i_addi, 32'd5, 32'h4, 1'b0, 32'h4, 1'b1, 2'd0);
      run_simple("fence", i_fence, 32'h0, 32'h8, 1'b0, 32'h8, 1'b0, 2'd0);

      // LW at 0x8 with three wait cycles on dmem_ready.
      sb.push_back('{exp_pc, 32'hC, 1'b1, 2'd1});
      exp_pc = 32'hC;
      instr = i_lw; instr_valid = 1'b1; alu_out = 32'h100; next_sel_address = 32'hC;
      cyc();
      instr_valid = 1'b0;
      look();
      check("lw_instr_q", instr_q, i_lw);
      check("lw_pc_stable", pc_address, 32'h8);
      cyc(); cyc();
      for (int k = 0; k < 4; k++) begin
         dmem_ready = (k == 3);
         look();
         check("lw_dmem_req", dmem_req, 1'b1);
         check("lw_dmem_we", dmem_we, 1'b0);
         check("lw_no_early_retire", retire, 1'b0);
         cyc();
      end
      dmem_ready = 1'b0;
      look();
      check("lw_alu_q", alu_q, 32'h100);
      check("lw_retire", retire, 1'b1);
      check("lw_wb_dmem_req", dmem_req, 1'b0);
      cyc();

      run_simple("fence2", i_fence, 32'h0, 32'h10, 1'b0, 32'h10, 1'b0, 2'd0);
      run_simple("beq_nt", i_beq, 32'h40, 32'h14, 1'b0, 32'h14, 1'b0, 2'd0);
      run_simple("jal_x0", i_jal0, 32'h10, 32'h18, 1'b0, 32'h10, 1'b0, 2'd2);
      run_simple("beq_t", i_beq, 32'h40, 32'h14, 1'b1, 32'h40, 1'b0, 2'd0);
      run_simple("jalr", i_jalr, 32'h101, 32'h44, 1'b0, 32'h100, 1'b1, 2'd2);

      // JALR to 0x102: misaligned target halts without retiring.
      instr = i_jalr; instr_valid = 1'b1; alu_out = 32'h102; next_sel_address = 32'h104;
      cyc();
      instr_valid = 1'b0;
      cyc(); cyc();
      look();
      check("jalr_mis_retire", retire, 1'b0);
      check("jalr_mis_rf_we", rf_we, 1'b0);
      cyc();
      look();
      check("jalr_mis_halted", halted, 1'b1);
      check("jalr_mis_pc", pc_address, 32'h100);
      for (int k = 0; k < 4; k++) begin
         cyc();
         instr_valid = k[0];
         dmem_ready  = 1'b1;
         look();
         check("halt_sticky", halted, 1'b1);
         check("halt_instr_req", instr_req, 1'b0);
         check("halt_dmem_req", dmem_req, 1'b0);
      end
      cyc();
      instr_valid = 1'b0; dmem_ready = 1'b0; rst = 1'b1;
      cyc();
      look();
      check("halt_rst_pc", pc_address, 32'h0);
      check("halt_rst_halted", halted, 1'b0);
      cyc();
      rst = 1'b0;
      exp_pc = 32'h0;

      // SYSTEM opcode at 0x4.
      run_simple("addi2", i_addi, 32'd5, 32'h4, 1'b0, 32'h4, 1'b1, 2'd0);
      instr = i_sys; instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0;
      look();
      check("sys_decode_not_halted", halted, 1'b0);
      cyc();
      look();
      check("sys_halted", halted, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         instr_valid = ~k[0];
         look();
         check("sys_sticky", halted, 1'b1);
         check("sys_no_retire", retire, 1'b0);
         check("sys_pc", pc_address, 32'h4);
      end
      cyc();
      instr_valid = 1'b0; rst = 1'b1;
      cyc();
      look();
      check("sys_rst_pc", pc_address, 32'h0);
      check("sys_rst_halted", halted, 1'b0);
      cyc();
      rst = 1'b0;
      exp_pc = 32'h0;

      // Store aborted by reset while waiting in MEMORY.
      instr = i_sw; instr_valid = 1'b1; alu_out = 32'h200; next_sel_address = 32'h4;
      cyc();
      instr_valid = 1'b0;
      cyc(); cyc();
      look();
      check("sw_dmem_req", dmem_req, 1'b1);
      check("sw_dmem_we", dmem_we, 1'b1);
      check("sw_wait_no_retire", retire, 1'b0);
      cyc();
      rst = 1'b1;
      cyc();
      look();
      check("abort_dmem_req", dmem_req, 1'b0);
      check("abort_retire", retire, 1'b0);
      check("abort_instr_req", instr_req, 1'b0);
      check("abort_pc", pc_address, 32'h0);
      cyc();
      rst = 1'b0;
      look();
      check("abort_instr_req_rise", instr_req, 1'b1);
      cyc();

      // Zero-wait store; dmem_ready held high is ignored until MEMORY.
      dmem_ready = 1'b1;
      run_simple("sw", i_sw, 32'h200, 32'h4, 1'b0, 32'h4, 1'b0, 2'd0);
      dmem_ready = 1'b0;

      check("sb_drained", 32'(sb.size()), 32'd0);
      cyc();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
